// File: rtl/pu_fx_mult.sv
`default_nettype none
// ============================================================================
// Module   : pu_fx_mult
// Purpose  : Pipelined signed fixed-point multiplier feeding a result FIFO
//            on the PU bus.
// Revision : 1.0  initial release
// ============================================================================
module pu_fx_mult #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int ATTR_WIDTH = 4,
    parameter int INVALID    = 0,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic                  signal_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [PW-1:0] ONE_PTR  = PW'(1);
    localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] r_a;
    logic                  r_inv_a;

    logic [LATENCY-1:0]    r_pv;
    logic [LATENCY-1:0]    r_pi;
    logic [DATA_WIDTH-1:0] r_pd [LATENCY];

    logic [DATA_WIDTH-1:0] r_mem_d [DEPTH];
    logic [DEPTH-1:0]      r_mem_i;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic [PROD_WIDTH-1:0]        w_a_ext;
    logic [PROD_WIDTH-1:0]        w_b_ext;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic signed [PROD_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH:0]          w_hi;
    logic                         w_ovf;
    logic [DATA_WIDTH-1:0]        w_res;
    logic                         w_res_inv;
    logic                         w_launch;
    logic                         w_push;
    logic                         w_pop;
    logic [CW-1:0]                w_inflight;
    logic                         w_full;
    logic                         w_attr_unused;

    assign w_attr_unused = ^attr_in;

    // Operands are sign-extended up front so the multiply is a plain
    // full-width signed product.
    assign w_a_ext = {{DATA_WIDTH{r_a[DATA_WIDTH-1]}}, r_a};
    assign w_b_ext = {{DATA_WIDTH{data_in[DATA_WIDTH-1]}}, data_in};
    assign w_prod  = $signed(w_a_ext) * $signed(w_b_ext);
    assign w_shift = w_prod >>> FRAC_WIDTH;

    // The rescaled value fits only if every bit above the result sign agrees with it.
    assign w_hi  = w_shift[PROD_WIDTH-1:DATA_WIDTH-1];
    assign w_ovf = ~((&w_hi) | ~(|w_hi));

    always_comb begin
        w_res = w_shift[DATA_WIDTH-1:0];
        if (w_ovf && (SATURATE != 0)) begin
            w_res = w_prod[PROD_WIDTH-1] ? SAT_NEG : SAT_POS;
        end
    end

    assign w_res_inv = r_inv_a | attr_in[INVALID] | w_ovf;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_pv[i]);
        end
    end

    assign w_full   = ((r_count + w_inflight) == FULL_CNT);
    assign full     = w_full;
    assign w_launch = signal_wr && signal_sel && !w_full;
    assign w_push   = r_pv[LATENCY-1];
    assign w_pop    = signal_oe && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_inv_a <= 1'b0;
        end else if (signal_wr && !signal_sel) begin
            r_a     <= data_in;
            r_inv_a <= attr_in[INVALID];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            r_pi <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_launch;
            r_pi[0] <= w_res_inv;
            r_pd[0] <= w_res;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pi[i] <= r_pi[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_d[r_wr_ptr] <= r_pd[LATENCY-1];
            r_mem_i[r_wr_ptr] <= r_pi[LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        attr_out = '0;
        if (w_pop) begin
            data_out          = r_mem_d[r_rd_ptr];
            attr_out[INVALID] = r_mem_i[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pu_fx_mult.sv
`default_nettype none
// Bench for pu_fx_mult: a saturating and a wrapping instance share stimulus and
// are checked every cycle against a queue-based model plus literal expectations.
module tb_pu_fx_mult;

    localparam int W   = 16;
    localparam int F   = 8;
    localparam int AW  = 4;
    localparam int INV = 0;
    localparam int LAT = 2;
    localparam int D   = 4;

    logic          clk;
    logic          rst;
    logic          signal_wr;
    logic          signal_sel;
    logic [W-1:0]  data_in;
    logic [AW-1:0] attr_in;
    logic          signal_oe;
    logic [W-1:0]  data_out_s, data_out_w;
    logic [AW-1:0] attr_out_s, attr_out_w;
    logic          full_s, full_w;

    int n_cmp  = 0;
    int n_fail = 0;

    pu_fx_mult #(.DATA_WIDTH(W), .FRAC_WIDTH(F), .ATTR_WIDTH(AW), .INVALID(INV),
                 .LATENCY(LAT), .DEPTH(D), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .signal_wr(signal_wr), .signal_sel(signal_sel),
        .data_in(data_in), .attr_in(attr_in), .signal_oe(signal_oe),
        .data_out(data_out_s), .attr_out(attr_out_s), .full(full_s));

    pu_fx_mult #(.DATA_WIDTH(W), .FRAC_WIDTH(F), .ATTR_WIDTH(AW), .INVALID(INV),
                 .LATENCY(LAT), .DEPTH(D), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .signal_wr(signal_wr), .signal_sel(signal_sel),
        .data_in(data_in), .attr_in(attr_in), .signal_oe(signal_oe),
        .data_out(data_out_w), .attr_out(attr_out_w), .full(full_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         due;
        logic [W-1:0] ds;
        logic [W-1:0] dw;
        bit         inv;
    } ent_t;

    ent_t         m_fly[$];
    ent_t         m_fifo[$];
    int           m_cyc = 0;
    logic [W-1:0] m_a = '0;
    bit           m_inv_a = 1'b0;
    bit           m_launch;

    function automatic ent_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit inv, input int due);
        longint p, r;
        bit     ovf;
        ent_t   e;
        p = longint'($signed(a)) * longint'($signed(b));
        r = p >>> F;
        ovf = (r > 32767) || (r < -32768);
        e.due = due;
        e.inv = inv | ovf;
        e.dw  = r[W-1:0];
        e.ds  = !ovf ? r[W-1:0] : ((p < 0) ? 16'h8000 : 16'h7FFF);
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fly.delete();
            m_fifo.delete();
            m_a = '0;
            m_inv_a = 1'b0;
        end else begin
            m_launch = signal_wr && signal_sel && ((m_fifo.size() + m_fly.size()) != D);
            m_cyc++;
            if (signal_oe && m_fifo.size() > 0) void'(m_fifo.pop_front());
            while (m_fly.size() > 0 && m_fly[0].due == m_cyc) m_fifo.push_back(m_fly.pop_front());
            if (m_launch)
                m_fly.push_back(mk(m_a, data_in, m_inv_a | attr_in[INV], m_cyc + LAT));
            if (signal_wr && !signal_sel) begin
                m_a = data_in;
                m_inv_a = attr_in[INV];
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0]  es, ew;
        logic [AW-1:0] ea;
        es = '0;
        ew = '0;
        ea = '0;
        if (signal_oe && m_fifo.size() > 0) begin
            es = m_fifo[0].ds;
            ew = m_fifo[0].dw;
            ea[INV] = m_fifo[0].inv;
        end
        chk("model_data_sat", 32'(data_out_s), 32'(es));
        chk("model_data_wrap", 32'(data_out_w), 32'(ew));
        chk("model_attr_sat", 32'(attr_out_s), 32'(ea));
        chk("model_attr_wrap", 32'(attr_out_w), 32'(ea));
        chk("model_full_sat", 32'(full_s), 32'((m_fifo.size() + m_fly.size()) == D));
        chk("model_full_wrap", 32'(full_w), 32'((m_fifo.size() + m_fly.size()) == D));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic write_a(input logic [W-1:0] d, input bit inv);
        signal_wr = 1'b1; signal_sel = 1'b0; data_in = d;
        attr_in = '0; attr_in[INV] = inv;
        cyc();
        signal_wr = 1'b0; attr_in = '0;
    endtask

    task automatic write_b(input logic [W-1:0] d, input bit inv);
        signal_wr = 1'b1; signal_sel = 1'b1; data_in = d;
        attr_in = '0; attr_in[INV] = inv;
        cyc();
        signal_wr = 1'b0; attr_in = '0;
    endtask

    task automatic read_chk(input string name, input logic [W-1:0] es,
                            input logic [W-1:0] ew, input bit inv);
        signal_oe = 1'b1;
        @(negedge clk);
        chk({name, "_sat"}, 32'(data_out_s), 32'(es));
        chk({name, "_wrap"}, 32'(data_out_w), 32'(ew));
        chk({name, "_inv"}, 32'(attr_out_s[INV]), 32'(inv));
        cyc();
        signal_oe = 1'b0;
    endtask

    initial begin
        rst = 1'b0; signal_wr = 1'b0; signal_sel = 1'b0;
        data_in = '0; attr_in = '0; signal_oe = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("reset_data", 32'(data_out_s), 32'h0);
        chk("reset_attr", 32'(attr_out_s), 32'h0);
        chk("reset_full", 32'(full_s), 32'h0);
        cyc(); cyc();
        rst = 1'b0; signal_oe = 1'b0;
        cyc();

        // basic Q8.8 products
        write_a(16'h0180, 1'b0);
        write_b(16'h0200, 1'b0);
        repeat (LAT) cyc();
        read_chk("mul_1p5x2", 16'h0300, 16'h0300, 1'b0);

        write_a(16'hFF80, 1'b0);
        write_b(16'h0300, 1'b0);
        repeat (LAT) cyc();
        read_chk("mul_neg", 16'hFE80, 16'hFE80, 1'b0);
        write_b(16'h0002, 1'b0);
        repeat (LAT) cyc();
        read_chk("mul_floor", 16'hFFFF, 16'hFFFF, 1'b0);

        // overflow both directions
        write_a(16'h4000, 1'b0);
        write_b(16'h0400, 1'b0);
        repeat (LAT) cyc();
        read_chk("ovf_pos", 16'h7FFF, 16'h0000, 1'b1);
        write_a(16'hC000, 1'b0);
        write_b(16'h0400, 1'b0);
        repeat (LAT) cyc();
        read_chk("ovf_neg", 16'h8000, 16'h0000, 1'b1);

        // invalid propagation from A and from B
        write_a(16'h1234, 1'b1);
        write_b(16'h0100, 1'b0);
        repeat (LAT) cyc();
        read_chk("inv_a", 16'h1234, 16'h1234, 1'b1);
        write_a(16'h0100, 1'b0);
        write_b(16'h0042, 1'b1);
        repeat (LAT) cyc();
        read_chk("inv_b", 16'h0042, 16'h0042, 1'b1);

        // fill to full, fifth launch rejected, launch+pop while full rejected
        for (int i = 1; i <= 4; i++) write_b(16'(i), 1'b0);
        signal_wr = 1'b1; signal_sel = 1'b1; data_in = 16'h0005;
        @(negedge clk);
        chk("full_after4", 32'(full_s), 32'h1);
        cyc();
        data_in = 16'h0077; signal_oe = 1'b1;
        @(negedge clk);
        chk("full_pop_data", 32'(data_out_s), 32'h0001);
        chk("full_pop_full", 32'(full_s), 32'h1);
        cyc();
        signal_wr = 1'b0; signal_oe = 1'b0;
        read_chk("q2", 16'h0002, 16'h0002, 1'b0);
        read_chk("q3", 16'h0003, 16'h0003, 1'b0);
        read_chk("q4", 16'h0004, 16'h0004, 1'b0);
        read_chk("q_empty", 16'h0000, 16'h0000, 1'b0);

        // interleaved push/pop across pointer wrap
        write_b(16'h0010, 1'b0);
        write_b(16'h0020, 1'b0);
        for (int i = 0; i < 7; i++) begin
            signal_wr = 1'b1; signal_sel = 1'b1; data_in = 16'(16'h0030 + 16 * i);
            signal_oe = 1'b1;
            cyc();
        end
        signal_wr = 1'b0;
        repeat (10) cyc();
        signal_oe = 1'b0;
        cyc();

        // async reset with two in flight and two queued
        for (int i = 1; i <= 4; i++) write_b(16'(16'h0100 * i), 1'b0);
        signal_oe = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("arst_data", 32'(data_out_s), 32'h0);
        chk("arst_attr", 32'(attr_out_s), 32'h0);
        chk("arst_full", 32'(full_s), 32'h0);
        cyc(); cyc();
        rst = 1'b0; signal_oe = 1'b0;
        cyc();
        write_b(16'h1234, 1'b0);
        repeat (LAT) cyc();
        read_chk("post_rst_a0", 16'h0000, 16'h0000, 1'b0);
        write_a(16'h0200, 1'b0);
        write_b(16'h0300, 1'b0);
        repeat (LAT) cyc();
        read_chk("post_rst_new", 16'h0600, 16'h0600, 1'b0);
        read_chk("post_rst_empty", 16'h0000, 16'h0000, 1'b0);

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
